vga_timing_gen: RTL and testbench

Raster timing generator for the background pipeline. It produces the pixel coordinates, blanking flag and sync pulses that the background pixel generators consume. A frame counter gives a synchronous scroll source. It counts pixel-clock-enabled cycles through a parameterised horizontal/vertical raster (default 640x480@60, 800x525 total) and delivers all outputs as registers, mutually aligned.

---
 rtl/vga_timing_gen.sv | 102 ++++++++++
 tb/tb_vga_timing_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, blanking, sync pulses and a frame
// counter, all registered and decoded from the next-count values so nothing skews.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          H_POL    = 1'b0,
   parameter bit          V_POL    = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_ce,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       video_active,
   output logic       hsync,
   output logic       vsync,
   output logic       line_start,
   output logic       frame_start,
   output logic [9:0] frame_count
);
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
         $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
      end
   endgenerate

   localparam logic [9:0]  X_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]  Y_LAST = 10'(V_TOTAL - 1);
   localparam logic [10:0] X_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] Y_ACT  = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0] r_x, r_y, r_fc;
   logic       r_va, r_hs, r_vs, r_ls, r_fs;

   logic       w_x_last, w_y_last;
   logic [9:0] w_nx_x, w_nx_y;
   logic       w_nx_va, w_nx_hs_on, w_nx_vs_on;

   always_comb begin
      w_x_last   = (r_x == X_LAST);
      w_y_last   = (r_y == Y_LAST);
      w_nx_x     = w_x_last ? '0 : r_x + 10'd1;
      w_nx_y     = r_y;
      if (w_x_last) begin
         w_nx_y = w_y_last ? '0 : r_y + 10'd1;
      end
      // Decode the coordinate about to be presented so levels land with it.
      w_nx_va    = ({1'b0, w_nx_x} < X_ACT) && ({1'b0, w_nx_y} < Y_ACT);
      w_nx_hs_on = ({1'b0, w_nx_x} >= HS_BEG) && ({1'b0, w_nx_x} < HS_END);
      w_nx_vs_on = ({1'b0, w_nx_y} >= VS_BEG) && ({1'b0, w_nx_y} < VS_END);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x  <= X_LAST;
         r_y  <= Y_LAST;
         r_va <= 1'b0;
         r_hs <= ~H_POL;
         r_vs <= ~V_POL;
         r_ls <= 1'b0;
         r_fs <= 1'b0;
         r_fc <= '0;
      end else begin
         r_ls <= 1'b0;
         r_fs <= 1'b0;
         if (pix_ce) begin
            r_x  <= w_nx_x;
            r_y  <= w_nx_y;
            r_va <= w_nx_va;
            r_hs <= w_nx_hs_on ? H_POL : ~H_POL;
            r_vs <= w_nx_vs_on ? V_POL : ~V_POL;
            r_ls <= w_x_last;
            r_fs <= w_x_last & w_y_last;
            if (w_x_last && w_y_last) begin
               r_fc <= r_fc + 10'd1;
            end
         end
      end
   end

   assign pix_x        = r_x;
   assign pix_y        = r_y;
   assign video_active = r_va;
   assign hsync        = r_hs;
   assign vsync        = r_vs;
   assign line_start   = r_ls;
   assign frame_start  = r_fs;
   assign frame_count  = r_fc;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 800x525 instance and a 12x7 instance, both
// compared against a linear pixel-index model of the raster.
module tb_vga_timing_gen;
   localparam int DHT = 800, DVT = 525;
   localparam int SHT = 12,  SVT = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       d_rst_n, d_ce, d_va, d_hs, d_vs, d_ls, d_fs;
   logic [9:0] d_x, d_y, d_fc;
   logic       s_rst_n, s_ce, s_va, s_hs, s_vs, s_ls, s_fs;
   logic [9:0] s_x, s_y, s_fc;

   vga_timing_gen u_dut (
      .clk(clk), .rst_n(d_rst_n), .pix_ce(d_ce),
      .pix_x(d_x), .pix_y(d_y), .video_active(d_va), .hsync(d_hs), .vsync(d_vs),
      .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) u_small (
      .clk(clk), .rst_n(s_rst_n), .pix_ce(s_ce),
      .pix_x(s_x), .pix_y(s_y), .video_active(s_va), .hsync(s_hs), .vsync(s_vs),
      .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
   );

   logic [34:0] d_act, s_act;
   assign d_act = {d_x, d_y, d_va, d_hs, d_vs, d_ls, d_fs, d_fc};
   assign s_act = {s_x, s_y, s_va, s_hs, s_vs, s_ls, s_fs, s_fc};

   int checks = 0;
   int errors = 0;

   // Model state: linear pixel index within the frame plus pulse/count state.
   int dn, dfc;
   bit dls, dfs;
   int sn, sfc;
   bit sls, sfs;

   function automatic logic [34:0] expect_state(input int n, input int ht,
         input int ha, input int hfp, input int hsw,
         input int va, input int vfp, input int vsw,
         input bit ls, input bit fs, input int fc);
      int x, y;
      bit act, hs_on, vs_on;
      x     = n % ht;
      y     = n / ht;
      act   = (x < ha) && (y < va);
      hs_on = (x >= ha + hfp) && (x < ha + hfp + hsw);
      vs_on = (y >= va + vfp) && (y < va + vfp + vsw);
      return {10'(x), 10'(y), act, !hs_on, !vs_on, ls, fs, 10'(fc)};
   endfunction

   function automatic logic [34:0] d_exp();
      return expect_state(dn, DHT, 640, 16, 96, 480, 10, 2, dls, dfs, dfc);
   endfunction

   function automatic logic [34:0] s_exp();
      return expect_state(sn, SHT, 8, 1, 2, 4, 1, 1, sls, sfs, sfc);
   endfunction

   task automatic d_reset_model();
      dn = DHT * DVT - 1; dfc = 0; dls = 1'b0; dfs = 1'b0;
   endtask

   task automatic s_reset_model();
      sn = SHT * SVT - 1; sfc = 0; sls = 1'b0; sfs = 1'b0;
   endtask

   task automatic d_cycle(input bit ce);
      d_ce = ce;
      @(posedge clk);
      if (ce) begin
         dn  = (dn + 1) % (DHT * DVT);
         dls = (dn % DHT == 0);
         dfs = (dn == 0);
         if (dfs) dfc = (dfc + 1) % 1024;
      end else begin
         dls = 1'b0; dfs = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic s_cycle(input bit ce);
      s_ce = ce;
      @(posedge clk);
      if (ce) begin
         sn  = (sn + 1) % (SHT * SVT);
         sls = (sn % SHT == 0);
         sfs = (sn == 0);
         if (sfs) sfc = (sfc + 1) % 1024;
      end else begin
         sls = 1'b0; sfs = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      d_rst_n = 1'b0; s_rst_n = 1'b0; d_ce = 1'b0; s_ce = 1'b0;
      d_reset_model(); s_reset_model();
      repeat (3) @(negedge clk);
      checks++;
      if ({d_x, d_y, d_va, d_hs, d_vs, d_ls, d_fs, d_fc} !==
          {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0}) begin
         errors++; $display("FAIL reset_values got %h want %h", d_act, d_exp());
      end
      checks++;
      if (s_act !== s_exp()) begin
         errors++; $display("FAIL small_reset got %h want %h", s_act, s_exp());
      end
      d_rst_n = 1'b1; s_rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         d_cycle(1'b0);
         checks++;
         if (d_act !== d_exp()) begin
            errors++; $display("FAIL reset_hold cyc=%0d got %h want %h", i, d_act, d_exp());
         end
      end
      d_cycle(1'b1);
      checks++;
      if ({d_x, d_y, d_va, d_ls, d_fs, d_fc} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 10'd1}) begin
         errors++; $display("FAIL first_pixel got %h want %h", d_act, d_exp());
      end
   endtask

   task automatic test_line();
      int hs_cnt = 0, hs_first = -1, act_cnt = 0, last_ls = -1, bad_period = 0, n_ls = 0;
      for (int i = 0; i < 1600; i++) begin
         d_cycle(1'b1);
         checks++;
         if (d_act !== d_exp()) begin
            errors++; $display("FAIL line_state cyc=%0d got %h want %h", i, d_act, d_exp());
         end
         if (d_y == 10'd1) begin
            if (!d_hs) begin
               hs_cnt++;
               if (hs_first < 0) hs_first = int'(d_x);
            end
            if (d_va) act_cnt++;
         end
         if (d_ls) begin
            if (last_ls >= 0 && i - last_ls != 800) bad_period++;
            last_ls = i;
            n_ls++;
         end
      end
      checks++;
      if (hs_cnt != 96) begin errors++; $display("FAIL hsync_width got %0d want 96", hs_cnt); end
      checks++;
      if (hs_first != 656) begin errors++; $display("FAIL hsync_start got %0d want 656", hs_first); end
      checks++;
      if (act_cnt != 640) begin errors++; $display("FAIL active_count got %0d want 640", act_cnt); end
      checks++;
      if (n_ls != 2 || bad_period != 0) begin
         errors++; $display("FAIL line_start_period pulses %0d bad %0d want 2 and 0", n_ls, bad_period);
      end
   endtask

   task automatic test_toggle();
      int hs_cnt = 0, n_ls = 0, dbl = 0;
      bit prev_ls = 1'b0, prev_fs = 1'b0;
      for (int i = 0; i < 1600; i++) begin
         d_cycle(i % 2 == 0);
         checks++;
         if (d_act !== d_exp()) begin
            errors++; $display("FAIL toggle_state cyc=%0d got %h want %h", i, d_act, d_exp());
         end
         if (!d_hs) hs_cnt++;
         if (d_ls) n_ls++;
         if ((d_ls && prev_ls) || (d_fs && prev_fs)) dbl++;
         prev_ls = d_ls; prev_fs = d_fs;
      end
      checks++;
      if (hs_cnt != 192) begin errors++; $display("FAIL toggle_hsync_width got %0d want 192", hs_cnt); end
      checks++;
      if (n_ls != 1 || dbl != 0) begin
         errors++; $display("FAIL toggle_pulses ls %0d double %0d want 1 and 0", n_ls, dbl);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         d_cycle(1'($urandom_range(0, 1)));
         checks++;
         if (d_act !== d_exp()) begin
            errors++; $display("FAIL random_state cyc=%0d got %h want %h", i, d_act, d_exp());
         end
      end
   endtask

   task automatic test_async_reset();
      int guard = 0;
      while (dn % DHT != 300 && guard < 1000) begin
         d_cycle(1'b1);
         guard++;
      end
      checks++;
      if (int'(d_x) != 300) begin errors++; $display("FAIL reach_x300 got %0d want 300", d_x); end
      #2 d_rst_n = 1'b0; d_ce = 1'b0;
      #1 d_reset_model();
      checks++;
      if ({d_x, d_y, d_va, d_hs, d_vs, d_ls, d_fs, d_fc} !==
          {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0}) begin
         errors++; $display("FAIL async_reset got %h want %h", d_act, d_exp());
      end
      @(negedge clk);
      d_rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d_cycle(1'b0);
         checks++;
         if (d_act !== d_exp()) begin
            errors++; $display("FAIL async_hold cyc=%0d got %h want %h", i, d_act, d_exp());
         end
      end
      d_cycle(1'b1);
      checks++;
      if ({d_x, d_y, d_va, d_ls, d_fs, d_fc} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 10'd1}) begin
         errors++; $display("FAIL async_restart got %h want %h", d_act, d_exp());
      end
   endtask

   task automatic test_small_frames();
      int seen = 0, cyc = 0, prev2 = -1, prev1 = -1;
      bit wrap_ok = 1'b0;
      while (seen < 1025 && cyc < 95000) begin
         s_cycle(cyc < 500 ? 1'($urandom_range(0, 1)) : 1'b1);
         cyc++;
         checks++;
         if (s_act !== s_exp()) begin
            errors++; $display("FAIL small_state cyc=%0d got %h want %h", cyc, s_act, s_exp());
         end
         if (s_fs) begin
            seen++;
            if (prev2 == 1023 && prev1 == 0 && s_fc == 10'd1) wrap_ok = 1'b1;
            prev2 = prev1;
            prev1 = int'(s_fc);
         end
      end
      checks++;
      if (seen < 1025) begin errors++; $display("FAIL small_timeout frames %0d want 1025", seen); end
      checks++;
      if (!wrap_ok) begin errors++; $display("FAIL small_fc_wrap last %0d %0d want 1023,0,1", prev2, prev1); end
   endtask

   initial begin
      test_reset();
      test_line();
      test_toggle();
      test_random();
      test_async_reset();
      test_small_frames();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
